// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if: request/operand and result bus of the chunked adder
interface seq_chunk_adder_if #(
  parameter int SIZE   = 4,
  parameter int CHUNKS = 4
);
  logic                   start;
  logic [SIZE*CHUNKS-1:0] a;
  logic [SIZE*CHUNKS-1:0] b;
  logic                   cin;
  logic                   busy;
  logic                   done;
  logic [SIZE*CHUNKS-1:0] sum;
  logic                   cout;
  logic                   ovf;
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: wide adder processing one SIZE-bit chunk per clock, LSB chunk first
module seq_chunk_adder #(
  parameter int SIZE   = 4,
  parameter int CHUNKS = 4
) (
  input logic              clk,
  input logic              rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int WIDTH = SIZE * CHUNKS;
  localparam int IW    = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t            r_state, w_next;
  logic [WIDTH-1:0]  r_a, r_b, r_psum, r_sum, w_psum;
  logic [IW-1:0]     r_idx;
  logic              r_carry, r_cout, r_ovf, r_done;
  logic [SIZE-1:0]   w_ach, w_bch, w_s;
  logic [SIZE:0]     w_c;
  logic              w_last;
  assign w_ach  = r_a[int'(r_idx)*SIZE +: SIZE];
  assign w_bch  = r_b[int'(r_idx)*SIZE +: SIZE];
  assign w_last = r_idx == IW'(CHUNKS - 1);
  assign w_c[0] = r_carry;
  genvar i;
  generate
    for (i = 0; i < SIZE; i++) begin : g_rca
      assign w_s[i]   = w_ach[i] ^ w_bch[i] ^ w_c[i];
      assign w_c[i+1] = (w_ach[i] & w_bch[i]) | (w_c[i] & (w_ach[i] ^ w_bch[i]));
    end
  endgenerate
  // partial sum with the current chunk merged in, so the final chunk reaches sum in the same edge
  always_comb begin
    w_psum = r_psum;
    w_psum[int'(r_idx)*SIZE +: SIZE] = w_s;
  end
  // next state: accept start only when idle, leave RUN after the last chunk
  always_comb begin
    w_next = r_state == IDLE ? (bus.start ? RUN : IDLE) : (w_last ? IDLE : RUN);
  end
  // state register
  always_ff @(posedge clk) begin
    r_state <= !rst_n ? IDLE : w_next;
  end
  // operand latch, chunk sequencing and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start) begin
          r_a     <= bus.a;
          r_b     <= bus.b;
          r_carry <= bus.cin;
          r_idx   <= '0;
        end
      end else begin
        r_psum  <= w_psum;
        r_carry <= w_c[SIZE];
        r_idx   <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) begin
          r_sum  <= w_psum;
          r_cout <= w_c[SIZE];
          r_ovf  <= w_c[SIZE-1] ^ w_c[SIZE];
          r_done <= 1'b1;
        end
      end
    end
  end
  assign bus.busy = r_state == RUN;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
endmodule
